frame_rx: RTL and testbench

- Serial-side receiver for the 32-bit command/value frame the DAC word generator produces: 16-bit command word first, then 16-bit value word, MSB first.
- Deserializes frames arriving on an asynchronous 3-wire link (sclk, sdi, cs_n) into the system clock domain.
- Presents command and value as parallel words with a one-cycle valid strobe, an error strobe for malformed frames, and a running frame count.
- Sits at the receiving end of the link, feeding the register/control logic downstream.

---
 rtl/frame_rx.sv | 166 ++++++++++++++++
 tb/tb_frame_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_rx.sv
// Receives 32-bit command/value frames from an async 3-wire link (sclk, sdi, cs_n) into the clk domain.
// Latency: cs_n rising at the pin -> frame_valid/frame_err after SYNC_STAGES+2 clks.
// No backpressure: strobes are single-cycle; optional command check under FRAME_RX_CMD_CHECK_EN.
module frame_rx #(
  parameter int                WORD_W      = 16,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WORD_W-1:0] EXP_CMD     = 16'h0C00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              sdi,
  input  logic              cs_n,
  output logic [WORD_W-1:0] command,
  output logic [WORD_W-1:0] value,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam int FRAME_W = 2 * WORD_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sdi_sync_q, cs_sync_q;
  logic                   sclk_dly_q, sdi_dly_q, cs_dly_q;
  logic                   sclk_rise_q, cs_rise_q, cs_fall_q;
  // Marks when the synchronizers hold real pin samples rather than reset values.
  logic [SYNC_STAGES+1:0] flush_q;

  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]  command_q, command_d;
  logic [WORD_W-1:0]  value_q, value_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic sclk_last, sdi_last, cs_last, sync_ready, cmd_ok;

  assign sclk_last  = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_last   = sdi_sync_q[SYNC_STAGES-1];
  assign cs_last    = cs_sync_q[SYNC_STAGES-1];
  assign sync_ready = flush_q[SYNC_STAGES+1];

`ifdef FRAME_RX_CMD_CHECK_EN
  assign cmd_ok = (shift_q[FRAME_W-1:WORD_W] == EXP_CMD);
`else
  logic unused_exp_cmd;
  assign unused_exp_cmd = ^EXP_CMD;
  assign cmd_ok         = 1'b1;
`endif

  // Synchronize the link pins and register edge flags; sdi is delayed alongside sclk so data lines up with its edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      sdi_sync_q  <= '0;
      cs_sync_q   <= '1;
      sclk_dly_q  <= 1'b0;
      sdi_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b1;
      sclk_rise_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      flush_q     <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sclk_dly_q  <= sclk_last;
      sdi_dly_q   <= sdi_last;
      cs_dly_q    <= cs_last;
      sclk_rise_q <= sclk_last & ~sclk_dly_q;
      cs_rise_q   <= cs_last & ~cs_dly_q;
      cs_fall_q   <= ~cs_last & cs_dly_q;
      flush_q     <= {flush_q[SYNC_STAGES:0], 1'b1};
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      command_q   <= '0;
      value_q     <= '0;
      frame_cnt_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      command_q   <= command_d;
      value_q     <= value_d;
      frame_cnt_q <= frame_cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  // Next-state: wait for a clean idle link, capture bits between cs_n edges, judge the frame on cs_n rise.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    command_d   = command_q;
    value_d     = value_q;
    frame_cnt_d = frame_cnt_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        // Require genuine samples so the reset value of the cs_n chain is not mistaken for an idle link.
        if (sync_ready && cs_last && cs_dly_q) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall_q) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // cs_n rise wins over a coincident sclk edge, which is dropped.
        if (cs_rise_q) begin
          state_d = IDLE;
          if ((bit_cnt_q == FRAME_BITS) && cmd_ok) begin
            command_d   = shift_q[FRAME_W-1:WORD_W];
            value_d     = shift_q[WORD_W-1:0];
            frame_cnt_d = frame_cnt_q + 16'd1;
            valid_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_rise_q) begin
          shift_d = {shift_q[FRAME_W-2:0], sdi_dly_q};
          if (bit_cnt_q != CNT_SAT) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign command     = command_q;
  assign value       = value_q;
  assign frame_cnt   = frame_cnt_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_frame_rx.sv
// Directed bench for frame_rx: good, short, long, empty, aborted, coincident-edge and wrapping frames.
// Checks strobe counts, outputs and cs_n-to-strobe latency against hand-computed values.
// Link is driven with sclk period 16 clks; all outputs sampled on the falling clk edge.
module tb_frame_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclk = 1'b0;
  logic        sdi = 1'b0;
  logic        cs_n = 1'b1;
  logic [15:0] command;
  logic [15:0] value;
  logic        frame_valid;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_seen = 0;
  int err_seen   = 0;
  int both_seen  = 0;
  int last_lat   = 0;
  int v0, e0;

  frame_rx dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .sdi        (sdi),
    .cs_n       (cs_n),
    .command    (command),
    .value      (value),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) valid_seen++;
    if (frame_err) err_seen++;
    if (frame_valid && frame_err) both_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic begin_frame();
    cs_n = 1'b0;
    clk_n(8);
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    clk_n(4);
    sclk = 1'b1;
    clk_n(8);
    sclk = 1'b0;
    clk_n(4);
  endtask

  task automatic send_bits(input logic [63:0] data, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(data[i]);
  endtask

  // Raise cs_n and measure clks until the first strobe (bounded).
  task automatic end_frame(input logic with_sclk);
    clk_n(4);
    cs_n = 1'b1;
    if (with_sclk) sclk = 1'b1;
    last_lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (frame_valid || frame_err) begin
        last_lat = i;
        break;
      end
    end
    sclk = 1'b0;
    clk_n(12);
  endtask

  task automatic frame(input logic [63:0] data, input int nbits);
    begin_frame();
    if (nbits > 0) send_bits(data, nbits - 1, 0);
    end_frame(1'b0);
  endtask

  task automatic snap();
    v0 = valid_seen;
    e0 = err_seen;
  endtask

  initial begin
    clk_n(3);
    check("reset_command", {16'h0, command}, 32'h0);
    check("reset_value", {16'h0, value}, 32'h0);
    check("reset_cnt", {16'h0, frame_cnt}, 32'h0);
    check("reset_strobes", {30'h0, frame_valid, frame_err}, 32'h0);
    reset = 1'b1;
    clk_n(10);

    // Good frame
    snap();
    frame(64'h0C00_0ABC, 32);
    check("good_valid_pulses", valid_seen - v0, 1);
    check("good_err_pulses", err_seen - e0, 0);
    check("good_latency", last_lat, 4);
    check("good_command", {16'h0, command}, 32'h0C00);
    check("good_value", {16'h0, value}, 32'h0ABC);
    check("good_cnt", {16'h0, frame_cnt}, 32'd1);

    // Short then long frame
    snap();
    frame(64'h7FFF_FFFF, 31);
    check("short_err_pulses", err_seen - e0, 1);
    frame(64'h1_2345_6789, 33);
    check("long_err_pulses", err_seen - e0, 2);
    frame(64'h0, 0);
    check("empty_err_pulses", err_seen - e0, 3);
    check("bad_valid_pulses", valid_seen - v0, 0);
    check("bad_command_hold", {16'h0, command}, 32'h0C00);
    check("bad_value_hold", {16'h0, value}, 32'h0ABC);
    check("bad_cnt_hold", {16'h0, frame_cnt}, 32'd1);

    // Reset in the middle of a frame
    snap();
    begin_frame();
    send_bits(64'h0C00_5555, 31, 15);
    reset = 1'b0;
    clk_n(3);
    check("midrst_command", {16'h0, command}, 32'h0);
    check("midrst_cnt", {16'h0, frame_cnt}, 32'h0);
    reset = 1'b1;
    clk_n(2);
    send_bits(64'h0C00_5555, 14, 0);
    end_frame(1'b0);
    check("midrst_no_valid", valid_seen - v0, 0);
    check("midrst_no_err", err_seen - e0, 0);
    frame(64'h0C00_0001, 32);
    check("after_rst_valid", valid_seen - v0, 1);
    check("after_rst_command", {16'h0, command}, 32'h0C00);
    check("after_rst_value", {16'h0, value}, 32'h0001);
    check("after_rst_cnt", {16'h0, frame_cnt}, 32'd1);

    // sclk rise coincident with cs_n rise
    snap();
    begin_frame();
    send_bits(64'h0C00_5A5A, 31, 0);
    sdi = 1'b1;
    end_frame(1'b1);
    check("simul_valid", valid_seen - v0, 1);
    check("simul_err", err_seen - e0, 0);
    check("simul_latency", last_lat, 4);
    check("simul_value", {16'h0, value}, 32'h5A5A);
    check("simul_cnt", {16'h0, frame_cnt}, 32'd2);

    // Unexpected command word
    snap();
    frame(64'h0D00_0123, 32);
`ifdef FRAME_RX_CMD_CHECK_EN
    check("cmd_err", err_seen - e0, 1);
    check("cmd_valid", valid_seen - v0, 0);
    check("cmd_command", {16'h0, command}, 32'h0C00);
    check("cmd_value", {16'h0, value}, 32'h5A5A);
    check("cmd_cnt", {16'h0, frame_cnt}, 32'd2);
`else
    check("cmd_err", err_seen - e0, 0);
    check("cmd_valid", valid_seen - v0, 1);
    check("cmd_command", {16'h0, command}, 32'h0D00);
    check("cmd_value", {16'h0, value}, 32'h0123);
    check("cmd_cnt", {16'h0, frame_cnt}, 32'd3);
`endif

    // frame_cnt wrap
    force dut.frame_cnt_q = 16'hFFFF;
    clk_n(2);
    release dut.frame_cnt_q;
    clk_n(2);
    check("wrap_preload", {16'h0, frame_cnt}, 32'hFFFF);
    snap();
    frame(64'h0C00_FFFF, 32);
    check("wrap_valid", valid_seen - v0, 1);
    check("wrap_cnt", {16'h0, frame_cnt}, 32'h0);
    check("wrap_value", {16'h0, value}, 32'hFFFF);

    check("never_both", both_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
